// File: rtl/sd_cmd_tx_ctrl_if.sv
// Host-side command handshake between the command register logic and
// sd_cmd_tx_ctrl.
//   start_i      request to send a frame (sampled with ready_o)
//   ready_o      controller idle and able to accept
//   cmd_index_i  6-bit command index, captured on accept
//   cmd_arg_i    32-bit argument, captured on accept
//   done_o       one-cycle pulse coinciding with the end bit
// master: host side, slave: the controller.
interface sd_cmd_tx_ctrl_if;
  logic        start_i;
  logic        ready_o;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic        done_o;

  modport master (
    output start_i, cmd_index_i, cmd_arg_i,
    input  ready_o, done_o
  );

  modport slave (
    input  start_i, cmd_index_i, cmd_arg_i,
    output ready_o, done_o
  );
endinterface

// File: rtl/sd_cmd_tx_ctrl.sv
// SD CMD-line frame transmitter. Sends one 48-bit command frame
// {start=0, tx=1, index[5:0], arg[31:0], crc7[6:0], end=1}, one bit per clk_i
// cycle, MSb first, and drives an external serial CRC7 generator: the 40
// header/argument bits are fed to it, then it is told to shift its result out.
//
// Ports:
//   clk_i        SD card clock, one CMD bit per cycle
//   rst_ni       synchronous active-low reset (shared with the CRC7 instance)
//   host         command handshake (sd_cmd_tx_ctrl_if.slave)
//   cmd_o        serial CMD data
//   cmd_oe_o     CMD pad output enable
//   crc_dat_o    serial data into the CRC7 generator
//   crc_shift_o  CRC7 generator shift-out select
//   crc_ser_i    CRC7 generator serial result (its registered MSb)
//   abort_i      (only with SDHCI_CMD_TX_ABORT_EN) abandon the frame in flight
//
// Parameter NCC_GAP (0..255): idle cycles with CMD released after the end bit.
//
// Build option: define SDHCI_CMD_TX_ABORT_EN to add abort_i. An abort during
// the header or CRC phase releases CMD on the next cycle, suppresses done_o,
// and flushes the CRC7 register with 7 zero shift-out cycles before the gap.
module sd_cmd_tx_ctrl #(
  parameter int unsigned NCC_GAP = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sd_cmd_tx_ctrl_if.slave  host,
`ifdef SDHCI_CMD_TX_ABORT_EN
  input  logic             abort_i,
`endif
  output logic             cmd_o,
  output logic             cmd_oe_o,
  output logic             crc_dat_o,
  output logic             crc_shift_o,
  input  logic             crc_ser_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CRC,
    S_END,
    S_GAP,
    S_FLUSH
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(NCC_GAP);

  state_t      state_q, state_d;
  // Bit counter covers the 40/7-cycle phases; the gap needs its own 8-bit
  // counter because NCC_GAP may exceed what 6 bits hold.
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [39:0] sreg_q, sreg_d;
  logic        abort_req;

`ifdef SDHCI_CMD_TX_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sreg_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sreg_q    <= sreg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sreg_d       = sreg_q;
    host.ready_o = 1'b0;
    host.done_o  = 1'b0;
    cmd_o        = 1'b1;
    cmd_oe_o     = 1'b0;
    crc_dat_o    = 1'b0;
    crc_shift_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        host.ready_o = 1'b1;
        if (host.start_i) begin
          state_d   = S_HDR;
          bit_cnt_d = 6'd40;
          sreg_d    = {2'b01, host.cmd_index_i, host.cmd_arg_i};
        end
      end

      S_HDR: begin
        cmd_o     = sreg_q[39];
        cmd_oe_o  = 1'b1;
        crc_dat_o = sreg_q[39];
        sreg_d    = {sreg_q[38:0], 1'b0};
        if (abort_req) begin
          state_d   = S_FLUSH;
          bit_cnt_d = 6'd7;
        end else if (bit_cnt_q == 6'd1) begin
          state_d   = S_CRC;
          bit_cnt_d = 6'd7;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      S_CRC: begin
        // The generator's MSb is already registered, so it can go straight
        // to the pad in the same cycle the shift is requested.
        cmd_o       = crc_ser_i;
        cmd_oe_o    = 1'b1;
        crc_shift_o = 1'b1;
        if (abort_req) begin
          // Restarting the flush count leaves the CRC register all-zero
          // regardless of how many result bits were already shifted out.
          state_d   = S_FLUSH;
          bit_cnt_d = 6'd7;
        end else if (bit_cnt_q == 6'd1) begin
          state_d   = S_END;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      S_END: begin
        cmd_o       = 1'b1;
        cmd_oe_o    = 1'b1;
        host.done_o = 1'b1;
        if (GAP_LOAD != 8'd0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      S_FLUSH: begin
        crc_shift_o = 1'b1;
        if (bit_cnt_q == 6'd1) begin
          bit_cnt_d = '0;
          if (GAP_LOAD != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
